// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the FIFO write port between
// NUM_REQ requesters in the wr_clk domain. A grant is held for a burst of up to
// MAX_BURST words. Writes stall while the FIFO reports full, and the grant is
// released early when the granted requester drops its valid.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            wr_clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            wr_en,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  grant_q, grant_nxt;
  logic [ID_W-1:0]  last_id, last_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;

  logic gnt_valid;
  logic accept;
  logic last_word;

  // Round-robin pick: first valid requester scanning last+1, last+2, ... modulo
  // NUM_REQ, so the most recently served requester has the lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && v[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign gnt_valid = req_valid[grant_q];
  assign accept    = (state == GRANT) && gnt_valid && !fifo_full;
  assign last_word = (burst_cnt == CNT_W'(MAX_BURST - 1));

  // State register: FSM state, grant index, round-robin pointer and burst count.
  // last_id resets to NUM_REQ-1 so that requester 0 wins the first arbitration.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      last_id   <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE; in GRANT count accepted words and
  // release on the final burst word or when the requester drops valid.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_id;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = GRANT;
          grant_nxt = rr_pick(req_valid, last_id);
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!gnt_valid) begin
          // Early end of burst; releases even while the FIFO is full.
          state_nxt = IDLE;
          last_nxt  = grant_q;
        end else if (accept) begin
          cnt_nxt = burst_cnt + CNT_W'(1);
          if (last_word) begin
            state_nxt = IDLE;
            last_nxt  = grant_q;
          end
        end
        // Full with valid held: grant and count stay frozen, no timeout.
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: combinational from registered state, req_valid and fifo_full
  // so a word is written in the same cycle it is accepted.
  always_comb begin
    req_ready = '0;
    wr_en     = accept;
    wr_data   = '0;
    busy      = (state == GRANT);
    if (state == GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == ID_W'(i)) begin
          wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      req_ready[grant_q] = accept;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single-requester bursts, round-robin
// rotation, early release, full stall and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 4;

  logic             wr_clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic [1:0]       grant_id;
  logic             busy;

  int               n_vec = 0;
  int               n_err = 0;

  // requester models: rem = words still to offer, dat = word currently offered
  int               rem [NR];
  logic [DW-1:0]    dat [NR];

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wr_clk    (wr_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (rem[i] > 0);
      req_data[i*DW +: DW]   = dat[i];
    end
  endtask

  // Check outputs mid-cycle, then advance the requester models on the edge.
  task automatic cyc(input string tag, input bit eb, input bit ew,
                     input logic [DW-1:0] ed, input int eg, input logic [NR-1:0] er);
    logic [NR-1:0] rdy;
    @(negedge wr_clk);
    chk({tag, ".busy"},  32'(busy),      32'(eb));
    chk({tag, ".wr_en"}, 32'(wr_en),     32'(ew));
    chk({tag, ".data"},  32'(wr_data),   32'(ed));
    chk({tag, ".gid"},   32'(grant_id),  32'(eg));
    chk({tag, ".ready"}, 32'(req_ready), 32'(er));
    rdy = req_ready;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy[i]) begin
        dat[i] = dat[i] + 16'd1;
        rem[i] = rem[i] - 1;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    apply();
    #2;
    chk("rst.wr_en", 32'(wr_en),     32'd0);
    chk("rst.data",  32'(wr_data),   32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.gid",   32'(grant_id),  32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int            ecnt [NR];
    int            prev;
    int            id;
    logic [DW-1:0] base;

    // ---- single requester: 4-word bursts separated by one idle cycle
    do_reset();
    rem[0] = 1000;
    dat[0] = 16'h1000;
    apply();
    base = 16'h1000;
    for (int c = 0; c < 10; c++) begin
      if (c % 5 == 0) cyc($sformatf("single%0d", c), 0, 0, 16'h0, 0, 4'b0000);
      else begin
        cyc($sformatf("single%0d", c), 1, 1, base, 0, 4'b0001);
        base = base + 16'd1;
      end
    end

    // ---- round-robin with all four valid: grants 0,1,2,3,0 of 4 words each
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 1000;
      dat[i]  = 16'h2000 + 16'(i * 16'h100);
      ecnt[i] = 0;
    end
    apply();
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      id = g % NR;
      cyc($sformatf("rr%0d.idle", g), 0, 0, 16'h0, prev, 4'b0000);
      for (int k = 0; k < MB; k++) begin
        cyc($sformatf("rr%0d.w%0d", g, k), 1, 1,
            16'h2000 + 16'(id * 16'h100) + 16'(ecnt[id]), id, 4'(1 << id));
        ecnt[id]++;
      end
      prev = id;
    end

    // ---- early release: id 2 sends 2 words and drops, id 3 is next
    do_reset();
    rem[2] = 2;    dat[2] = 16'h3200;
    rem[3] = 1000; dat[3] = 16'h3300;
    apply();
    cyc("early.idle0", 0, 0, 16'h0,    0, 4'b0000);
    cyc("early.w0",    1, 1, 16'h3200, 2, 4'b0100);
    cyc("early.w1",    1, 1, 16'h3201, 2, 4'b0100);
    cyc("early.drop",  1, 0, 16'h3202, 2, 4'b0000);
    cyc("early.idle1", 0, 0, 16'h0,    2, 4'b0000);
    cyc("early.n0",    1, 1, 16'h3300, 3, 4'b1000);
    cyc("early.n1",    1, 1, 16'h3301, 3, 4'b1000);

    // ---- full stall for 5 cycles after word 2 of 4
    do_reset();
    rem[0] = 1000;
    dat[0] = 16'h4000;
    apply();
    cyc("full.idle0", 0, 0, 16'h0,    0, 4'b0000);
    cyc("full.w0",    1, 1, 16'h4000, 0, 4'b0001);
    cyc("full.w1",    1, 1, 16'h4001, 0, 4'b0001);
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++)
      cyc($sformatf("full.stall%0d", s), 1, 0, 16'h4002, 0, 4'b0000);
    fifo_full = 1'b0;
    cyc("full.w2",    1, 1, 16'h4002, 0, 4'b0001);
    cyc("full.w3",    1, 1, 16'h4003, 0, 4'b0001);
    cyc("full.idle1", 0, 0, 16'h0,    0, 4'b0000);

    // ---- asynchronous reset mid-burst, then requester 1 wins first
    do_reset();
    rem[2] = 1000;
    dat[2] = 16'h5200;
    apply();
    cyc("arst.idle", 0, 0, 16'h0,    0, 4'b0000);
    cyc("arst.w0",   1, 1, 16'h5200, 2, 4'b0100);
    @(negedge wr_clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.wr_en", 32'(wr_en),     32'd0);
    chk("arst.ready", 32'(req_ready), 32'd0);
    chk("arst.busy",  32'(busy),      32'd0);
    chk("arst.gid",   32'(grant_id),  32'd0);
    chk("arst.data",  32'(wr_data),   32'd0);
    @(posedge wr_clk);
    #1;
    rem[2] = 0;
    rem[1] = 1000;
    dat[1] = 16'h5100;
    apply();
    rst_n = 1'b1;
    cyc("arst.idle1", 0, 0, 16'h0,    0, 4'b0000);
    cyc("arst.g1w0",  1, 1, 16'h5100, 1, 4'b0010);
    cyc("arst.g1w1",  1, 1, 16'h5101, 1, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
